wb_stage: RTL and testbench
===========================

# wb_stage

Final writeback stage of the five-stage pipeline. It latches the MEM/WB pipeline register and performs load-data alignment with sign or zero extension. It selects the writeback value (`outMuxWb`) and drives the register-file write port. It also keeps a retired-instruction counter that the bench uses to check pipeline progress clock by clock.

## Interface
- `DATA_W`, 32, datapath width (load alignment logic is defined for 32 only)
- `REG_ADDR_W`, 5, register-file address width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold the stage register contents
- `flush`  in  1  replace incoming entry with a bubble
- `in_valid`  in  1  MEM stage holds a real instruction
- `in_reg_write`  in  1  instruction writes the register file
- `in_mem_to_reg`  in  1  1 = writeback from load data, 0 = from ALU result
- `in_load_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `in_load_unsigned`  in  1  1 = zero-extend, 0 = sign-extend (byte/half only)
- `in_addr_low`  in  2  byte offset of the load address
- `in_mem_data`  in  DATA_W  raw aligned word from data memory
- `in_alu_result`  in  DATA_W  ALU result from MEM stage
- `in_rd`  in  REG_ADDR_W  destination register
- `outMuxWb`  out  DATA_W  writeback value
- `wb_reg_write`  out  1  register-file write enable
- `wb_rd`  out  REG_ADDR_W  register-file write address
- `wb_valid`  out  1  stage holds a real instruction
- `retired_count`  out  32  count of valid instructions loaded into the stage

## Operation
- Stage register fields: valid, reg_write, mem_to_reg, load_size, load_unsigned, addr_low, mem_data, alu_result, rd.
- Edge priority is reset > flush > stall > load.
  - reset: all fields are cleared to 0. `retired_count` = 0.
  - flush: valid and reg_write are cleared. The other fields are cleared to 0. This applies even when `stall` = 1.
  - stall (no flush): all fields hold. The counter holds.
  - otherwise: all fields load from the `in_*` inputs.
- `retired_count` increments by 1 on every load edge with `in_valid` = 1. It wraps 0xFFFFFFFF -> 0.
- Load alignment is little-endian:
  - Byte: select bits [8*addr_low+7 : 8*addr_low].
  - Half: select bits [15:0] when addr_low[1] = 0, and [31:16] when addr_low[1] = 1. addr_low[0] is ignored; there is no misalignment trap.
  - Word: the full word. addr_low is ignored.
  - Extension comes from load_unsigned.
- `outMuxWb` = mem_to_reg ? aligned load data : alu_result. It is combinational from the stage register only; there is no path from the `in_*` inputs.
- `wb_reg_write` = valid & reg_write & (rd != 0). Writes to r0 are suppressed.
- `wb_rd` = rd. `wb_valid` = valid.

## Timing
- Latency is one cycle. Inputs sampled at edge N appear on the outputs after edge N and stay until edge N+1.
- Reset values: `outMuxWb` = 0, `wb_reg_write` = 0, `wb_rd` = 0, `wb_valid` = 0, `retired_count` = 0.
- Reset asserted mid-stream clears everything at that edge, regardless of stall/flush. The first load takes place on the first edge with `reset` = 0.
- A stall held for K cycles keeps the outputs constant for K cycles. It produces no duplicate count and no duplicate register-file write. Downstream must not treat a held entry as a second write; the register file is idempotent.
- Flush with `in_valid` = 1 does not increment the counter.
- There is no combinational path from any input to any output.

## Test plan
- Reset: assert `reset` for 2 edges with random inputs -> all outputs are 0. Release, load ALU op (alu_result 0x0000002A, rd 3, reg_write 1, valid 1) -> after the next edge `outMuxWb` = 0x2A, `wb_reg_write` = 1, `wb_rd` = 3, `retired_count` = 1.
- Load extension with mem_data 0x80FF7F01:
  - byte offset 2, signed -> 0xFFFFFFFF.
  - byte offset 3, unsigned -> 0x00000080.
  - half offset 0, signed -> 0x00007F01.
  - half offset 2, signed -> 0xFFFF80FF.
  - word -> 0x80FF7F01.
- r0 suppression: valid ALU write to rd 0 with value 0x1234 -> `outMuxWb` = 0x1234, `wb_reg_write` = 0, count +1.
- Stall/flush priority:
  - Load entry A, then stall 3 edges with entry B on the inputs -> outputs stay A and count stays at 1.
  - Assert stall and flush together -> `wb_valid` = 0, `wb_reg_write` = 0, `outMuxWb` = 0, count unchanged.
- Counter wrap: run 8 consecutive valid loads, a flush-only edge and an invalid edge -> count = 8. Separately preload near 0xFFFFFFFF via a long run in simulation -> next valid load gives 0.
- Mid-operation reset: assert reset during a stall with a valid entry held -> next outputs all 0, count 0. Release reset and load a load with load_size 11 -> treated as word.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with load alignment, writeback select and a retired-instruction counter.
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_unsigned,
    input  logic [1:0]            in_addr_low,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic [DATA_W-1:0]     outMuxWb,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_valid,
    output logic [31:0]           retired_count
);
    logic                  valid_q, reg_write_q, mem_to_reg_q, load_unsigned_q;
    logic [1:0]            load_size_q, addr_low_q;
    logic [DATA_W-1:0]     mem_data_q, alu_result_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [31:0]           count_q, count_d;
    logic [DATA_W-1:0]     shifted, load_data;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign count_d = count_q + {31'd0, in_valid};

    // Flush wins over stall; it clears the entry but leaves the counter alone.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            load_size_q     <= 2'b00;
            load_unsigned_q <= 1'b0;
            addr_low_q      <= 2'b00;
            mem_data_q      <= '0;
            alu_result_q    <= '0;
            rd_q            <= '0;
            if (reset) count_q <= 32'd0;
        end else if (!stall) begin
            valid_q         <= in_valid;
            reg_write_q     <= in_reg_write;
            mem_to_reg_q    <= in_mem_to_reg;
            load_size_q     <= in_load_size;
            load_unsigned_q <= in_load_unsigned;
            addr_low_q      <= in_addr_low;
            mem_data_q      <= in_mem_data;
            alu_result_q    <= in_alu_result;
            rd_q            <= in_rd;
            count_q         <= count_d;
        end
    end

    always_comb begin
        shifted   = mem_data_q >> {addr_low_q, 3'b000};
        byte_sel  = shifted[7:0];
        half_sel  = addr_low_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];
        load_data = load_size_q == 2'b00 ? {{(DATA_W-8){~load_unsigned_q & byte_sel[7]}}, byte_sel}
                  : load_size_q == 2'b01 ? {{(DATA_W-16){~load_unsigned_q & half_sel[15]}}, half_sel}
                  : mem_data_q;
    end

    assign outMuxWb      = mem_to_reg_q ? load_data : alu_result_q;
    assign wb_reg_write  = valid_q & reg_write_q & (rd_q != '0);
    assign wb_rd         = rd_q;
    assign wb_valid      = valid_q;
    assign retired_count = count_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with an independent stage model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_unsigned;
    logic [1:0]  in_load_size, in_addr_low;
    logic [31:0] in_mem_data, in_alu_result;
    logic [4:0]  in_rd;
    logic [31:0] outMuxWb, retired_count;
    logic        wb_reg_write, wb_valid;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] wb;
        logic        rw;
        logic [4:0]  rd;
        logic        v;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    logic        m_v, m_rw, m_m2r, m_uns;
    logic [1:0]  m_sz, m_al;
    logic [31:0] m_md, m_alu, m_cnt;
    logic [4:0]  m_rd;

    wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .in_addr_low(in_addr_low), .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .outMuxWb(outMuxWb), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_valid(wb_valid), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [1:0] sz, input logic uns,
                                          input logic [1:0] al, input logic [31:0] md);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'b00: begin
                case (al)
                    2'd0: b = md[7:0];
                    2'd1: b = md[15:8];
                    2'd2: b = md[23:16];
                    default: b = md[31:24];
                endcase
                return uns ? {24'd0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = al[1] ? md[31:16] : md[15:0];
                return uns ? {16'd0, h} : {{16{h[15]}}, h};
            end
            default: return md;
        endcase
    endfunction

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                         input logic uns, input logic [1:0] al, input logic [31:0] md,
                         input logic [31:0] alu, input logic [4:0] rd);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_load_size = sz;
        in_load_unsigned = uns; in_addr_low = al; in_mem_data = md; in_alu_result = alu; in_rd = rd;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
              $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    task automatic step(input string tag);
        exp_t e, o;
        if (reset || flush) begin
            {m_v, m_rw, m_m2r, m_uns, m_sz, m_al, m_md, m_alu, m_rd} = '0;
            if (reset) m_cnt = 32'd0;
        end else if (!stall) begin
            {m_v, m_rw, m_m2r, m_uns, m_sz, m_al} =
                {in_valid, in_reg_write, in_mem_to_reg, in_load_unsigned, in_load_size, in_addr_low};
            m_md = in_mem_data; m_alu = in_alu_result; m_rd = in_rd;
            if (in_valid) m_cnt = m_cnt + 32'd1;
        end
        e.wb  = m_m2r ? align(m_sz, m_uns, m_al, m_md) : m_alu;
        e.rw  = m_v && m_rw && m_rd != 5'd0;
        e.rd  = m_rd;
        e.v   = m_v;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check({tag, ".wb"}, outMuxWb, o.wb);
        check({tag, ".rw"}, {31'd0, wb_reg_write}, {31'd0, o.rw});
        check({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, o.rd});
        check({tag, ".v"}, {31'd0, wb_valid}, {31'd0, o.v});
        check({tag, ".cnt"}, retired_count, o.cnt);
    endtask

    localparam logic [31:0] MD = 32'h80FF7F01;

    initial begin
        {m_v, m_rw, m_m2r, m_uns, m_sz, m_al, m_md, m_alu, m_rd, m_cnt} = '0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_rand(); step("rst0");
        drive_rand(); step("rst1");
        check("rst_zero_wb", outMuxWb, 32'd0);
        check("rst_zero_cnt", retired_count, 32'd0);
        reset = 1'b0;
        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'd0, 32'h2A, 5'd3); step("alu");
        check("alu_wb", outMuxWb, 32'h2A);
        check("alu_cnt", retired_count, 32'd1);

        drive(1, 1, 1, 2'b00, 0, 2'd2, MD, 32'hDEAD, 5'd4); step("lb2s");
        check("lb2s_val", outMuxWb, 32'hFFFFFFFF);
        drive(1, 1, 1, 2'b00, 1, 2'd3, MD, 32'hDEAD, 5'd5); step("lb3u");
        check("lb3u_val", outMuxWb, 32'h00000080);
        drive(1, 1, 1, 2'b01, 0, 2'd0, MD, 32'hDEAD, 5'd6); step("lh0s");
        check("lh0s_val", outMuxWb, 32'h00007F01);
        drive(1, 1, 1, 2'b01, 0, 2'd2, MD, 32'hDEAD, 5'd7); step("lh2s");
        check("lh2s_val", outMuxWb, 32'hFFFF80FF);
        drive(1, 1, 1, 2'b01, 1, 2'd3, MD, 32'hDEAD, 5'd7); step("lh3u");
        check("lh3u_val", outMuxWb, 32'h000080FF);
        drive(1, 1, 1, 2'b00, 0, 2'd1, MD, 32'hDEAD, 5'd8); step("lb1s");
        drive(1, 1, 1, 2'b10, 0, 2'd1, MD, 32'hDEAD, 5'd9); step("lw");
        check("lw_val", outMuxWb, MD);

        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'd0, 32'h1234, 5'd0); step("r0");
        check("r0_rw", {31'd0, wb_reg_write}, 32'd0);

        drive(1, 1, 0, 2'b10, 0, 2'd0, 32'd0, 32'hAAAA0001, 5'd10); step("entA");
        stall = 1'b1;
        drive(1, 1, 1, 2'b00, 1, 2'd1, MD, 32'hBBBB0002, 5'd11);
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_holdA", outMuxWb, 32'hAAAA0001);
        flush = 1'b1; step("stflush");
        check("stflush_v", {31'd0, wb_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        reset = 1'b1; drive_rand(); step("rst2"); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 2'b10, 0, 2'd0, 32'd0, 32'(i * 3), 5'(i + 1)); step("run8");
        end
        flush = 1'b1; drive(1, 1, 0, 2'b10, 0, 2'd0, 32'd0, 32'h55, 5'd1); step("fl_only");
        flush = 1'b0; drive(0, 1, 0, 2'b10, 0, 2'd0, 32'd0, 32'h66, 5'd2); step("inval");
        check("run8_cnt", retired_count, 32'd8);

        drive(1, 1, 1, 2'b00, 0, 2'd2, MD, 32'd0, 5'd12); step("preheld");
        stall = 1'b1; drive_rand(); step("held");
        reset = 1'b1; step("midrst");
        check("midrst_cnt", retired_count, 32'd0);
        reset = 1'b0; stall = 1'b0;
        drive(1, 1, 1, 2'b11, 0, 2'd3, MD, 32'd0, 5'd13); step("ls11");
        check("ls11_word", outMuxWb, MD);

        for (int i = 0; i < 60; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            drive_rand(); step("rand");
        end
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
